id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarding and operand selection at
// capture time, holds the instruction under backpressure, and flags
// load-use hazards against the instruction it currently holds.
module id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm16,
    input  logic [4:0]  shamt,
    input  logic [3:0]  aluc_in,
    input  logic        a_sel,
    input  logic [1:0]  b_sel,
    input  logic        wb_en_in,
    input  logic        is_load_in,
    input  logic        exm_wen,
    input  logic        mw_wen,
    input  logic [4:0]  exm_waddr,
    input  logic [4:0]  mw_waddr,
    input  logic [31:0] exm_wdata,
    input  logic [31:0] mw_wdata,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  aluc,
    output logic [4:0]  dst_addr,
    output logic        wb_en,
    output logic        is_load,
    output logic        load_use_stall
);

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] alu_a_d;
    logic [31:0] alu_b_d;
    logic        capture;

    // Hazard detection and handshake
    always_comb begin
        load_use_stall = out_valid & is_load & (dst_addr != 5'd0) & in_valid &
                         ((dst_addr == rs_addr) | (dst_addr == rt_addr));
        in_ready       = (~out_valid | out_ready) & ~load_use_stall & ~flush;
        capture        = in_valid & in_ready;
    end

    // Operand forwarding: EX/MEM result wins over MEM/WB; register 0 never forwards
    always_comb begin
        fwd_rs = rs_val;
        fwd_rt = rt_val;
        if (FWD_EN) begin
            if (exm_wen && (exm_waddr == rs_addr) && (rs_addr != 5'd0))
                fwd_rs = exm_wdata;
            else if (mw_wen && (mw_waddr == rs_addr) && (rs_addr != 5'd0))
                fwd_rs = mw_wdata;
            if (exm_wen && (exm_waddr == rt_addr) && (rt_addr != 5'd0))
                fwd_rt = exm_wdata;
            else if (mw_wen && (mw_waddr == rt_addr) && (rt_addr != 5'd0))
                fwd_rt = mw_wdata;
        end
    end

    // ALU operand selection
    always_comb begin
        alu_a_d = a_sel ? {27'd0, shamt} : fwd_rs;
        alu_b_d = fwd_rt;
        unique case (b_sel)
            2'd1:    alu_b_d = {{16{imm16[15]}}, imm16};
            2'd2:    alu_b_d = {16'd0, imm16};
            default: alu_b_d = fwd_rt;
        endcase
    end

    // Pipeline register: flush beats capture, capture beats drain; data only changes on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            aluc      <= '0;
            dst_addr  <= '0;
            wb_en     <= 1'b0;
            is_load   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            aluc      <= aluc_in;
            dst_addr  <= rd_addr;
            wb_en     <= wb_en_in & (rd_addr != 5'd0);
            is_load   <= is_load_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_val, rt_val;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [3:0]  aluc_in;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic        wb_en_in, is_load_in;
    logic        exm_wen, mw_wen;
    logic [4:0]  exm_waddr, mw_waddr;
    logic [31:0] exm_wdata, mw_wdata;
    logic        flush, out_ready, out_valid;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  aluc;
    logic [4:0]  dst_addr;
    logic        wb_en, is_load, load_use_stall;

    int checks = 0;
    int errors = 0;

    // Reference model state: the instruction the stage should be holding
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_aluc;
    logic [4:0]  m_dst;
    logic        m_wb, m_load;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .shamt(shamt),
        .aluc_in(aluc_in), .a_sel(a_sel), .b_sel(b_sel),
        .wb_en_in(wb_en_in), .is_load_in(is_load_in),
        .exm_wen(exm_wen), .mw_wen(mw_wen), .exm_waddr(exm_waddr), .mw_waddr(mw_waddr),
        .exm_wdata(exm_wdata), .mw_wdata(mw_wdata), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc),
        .dst_addr(dst_addr), .wb_en(wb_en), .is_load(is_load), .load_use_stall(load_use_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Most recent in-flight producer of a register wins; register 0 is never produced
    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (exm_wen && exm_waddr == src) return exm_wdata;
        if (mw_wen && mw_waddr == src) return mw_wdata;
        return rf;
    endfunction

    function automatic logic model_stall();
        return m_valid && m_load && m_dst != 0 && in_valid &&
               (m_dst == rs_addr || m_dst == rt_addr);
    endfunction

    function automatic logic model_ready();
        return (!m_valid || out_ready) && !model_stall() && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_aluc = 0; m_dst = 0; m_wb = 0; m_load = 0;
    endtask

    task automatic model_edge();
        logic accept;
        accept = in_valid && model_ready();
        if (flush) begin
            m_valid = 0;
        end else if (accept) begin
            m_valid = 1;
            m_a     = a_sel ? 32'(shamt) : operand(rs_addr, rs_val);
            case (b_sel)
                2'd1:    m_b = 32'($signed(imm16));
                2'd2:    m_b = 32'(imm16);
                default: m_b = operand(rt_addr, rt_val);
            endcase
            m_aluc = aluc_in;
            m_dst  = rd_addr;
            m_wb   = wb_en_in && rd_addr != 0;
            m_load = is_load_in;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".alu_a"},     alu_a,          m_a);
        chk({tag, ".alu_b"},     alu_b,          m_b);
        chk({tag, ".aluc"},      32'(aluc),      32'(m_aluc));
        chk({tag, ".dst_addr"},  32'(dst_addr),  32'(m_dst));
        chk({tag, ".wb_en"},     32'(wb_en),     32'(m_wb));
        chk({tag, ".is_load"},   32'(is_load),   32'(m_load));
    endtask

    // One cycle: check combinational outputs, clock, then check the registers
    task automatic step(input string tag);
        #1;
        chk({tag, ".in_ready"},       32'(in_ready),       32'(model_ready()));
        chk({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_val = 0; rt_val = 0;
        imm16 = 0; shamt = 0; aluc_in = 0; a_sel = 0; b_sel = 0; wb_en_in = 0;
        is_load_in = 0; exm_wen = 0; mw_wen = 0; exm_waddr = 0; mw_waddr = 0;
        exm_wdata = 0; mw_wdata = 0; flush = 0; out_ready = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        check_regs("reset");
        #11 rst_n = 1;

        // Back-to-back issue
        in_valid = 1; out_ready = 1; aluc_in = 4'd2; rs_val = 5; rt_val = 7;
        rs_addr = 1; rt_addr = 2; rd_addr = 3; wb_en_in = 1;
        for (int i = 0; i < 3; i++) begin
            step("b2b");
            chk("b2b.alu_a_const", alu_a, 32'd5);
            chk("b2b.alu_b_const", alu_b, 32'd7);
        end

        // Forwarding priority
        rs_addr = 8; exm_wen = 1; exm_waddr = 8; exm_wdata = 32'hAAAA0000;
        mw_wen = 1; mw_waddr = 8; mw_wdata = 32'h1234;
        step("fwd_exm");
        chk("fwd_exm.const", alu_a, 32'hAAAA0000);
        exm_wen = 0;
        step("fwd_mw");
        chk("fwd_mw.const", alu_a, 32'h1234);
        exm_wen = 1; rs_addr = 0; exm_waddr = 0; mw_waddr = 0; rs_val = 32'h55;
        step("fwd_r0");
        chk("fwd_r0.const", alu_a, 32'h55);
        exm_wen = 0; mw_wen = 0;

        // Load-use hazard
        is_load_in = 1; rd_addr = 9; rs_addr = 1; rt_addr = 2;
        step("ld_cap");
        is_load_in = 0; rd_addr = 4; rt_addr = 9;
        #1;
        chk("ld_use.stall_const", 32'(load_use_stall), 32'd1);
        chk("ld_use.ready_const", 32'(in_ready), 32'd0);
        step("ld_bubble");
        chk("ld_bubble.valid_const", 32'(out_valid), 32'd0);
        step("ld_after");
        chk("ld_after.valid_const", 32'(out_valid), 32'd1);

        // Backpressure then flush
        rt_addr = 2; out_ready = 0; rs_val = 32'hDEAD; aluc_in = 4'd7;
        for (int i = 0; i < 4; i++) step("bp");
        chk("bp.aluc_held", 32'(aluc), 32'd2);
        flush = 1; in_valid = 1;
        step("flush");
        chk("flush.valid_const", 32'(out_valid), 32'd0);
        flush = 0; out_ready = 1;

        // Immediates, shift amount, every opcode, write to r0
        imm16 = 16'h8001; b_sel = 1;
        step("imm_sext");
        chk("imm_sext.const", alu_b, 32'hFFFF8001);
        b_sel = 2;
        step("imm_zext");
        chk("imm_zext.const", alu_b, 32'h00008001);
        a_sel = 1; shamt = 5'd31;
        step("shamt");
        chk("shamt.const", alu_a, 32'h0000001F);
        a_sel = 0; b_sel = 3;
        for (int c = 0; c < 16; c++) begin
            aluc_in = 4'(c);
            step("aluc");
        end
        rd_addr = 0; wb_en_in = 1;
        step("rd0");
        chk("rd0.wb_const", 32'(wb_en), 32'd0);

        // Asynchronous reset between edges
        rd_addr = 5; rs_val = 32'h77;
        step("pre_rst");
        #2 rst_n = 0;
        #1;
        model_reset();
        check_regs("async_rst");
        #2 rst_n = 1;
        step("post_rst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 11) == 0);
            rs_addr    = 5'($urandom_range(0, 7));
            rt_addr    = 5'($urandom_range(0, 7));
            rd_addr    = 5'($urandom_range(0, 7));
            rs_val     = $urandom;
            rt_val     = $urandom;
            imm16      = 16'($urandom);
            shamt      = 5'($urandom);
            aluc_in    = 4'($urandom);
            a_sel      = 1'($urandom);
            b_sel      = 2'($urandom);
            wb_en_in   = 1'($urandom);
            is_load_in = ($urandom_range(0, 2) == 0);
            exm_wen    = 1'($urandom);
            mw_wen     = 1'($urandom);
            exm_waddr  = 5'($urandom_range(0, 7));
            mw_waddr   = 5'($urandom_range(0, 7));
            exm_wdata  = $urandom;
            mw_wdata   = $urandom;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
